// File: rtl/mag_sqrd_integrator_if.sv
`default_nettype none
// ============================================================================
// mag_sqrd_integrator_if : sample/threshold inputs and window result outputs
// Rev 1.0 - initial release
// ============================================================================
interface mag_sqrd_integrator_if #(
  parameter int DW = 16
);
  logic [2*DW-1:0] mag_sqrd_i;
  logic            valid_i;
  logic            clear_i;
  logic [2*DW-1:0] threshold_i;
  logic [2*DW-1:0] power_o;
  logic            valid_o;
  logic            detect_o;
  logic [2*DW-1:0] peak_o;

  modport master (
    output mag_sqrd_i, valid_i, clear_i, threshold_i,
    input  power_o, valid_o, detect_o, peak_o
  );

  modport slave (
    input  mag_sqrd_i, valid_i, clear_i, threshold_i,
    output power_o, valid_o, detect_o, peak_o
  );
endinterface
`default_nettype wire

// File: rtl/mag_sqrd_integrator.sv
`default_nettype none
// ============================================================================
// mag_sqrd_integrator : N-sample mean power with hysteretic detect and an
// optional per-window peak (enabled by macro PEAK_HOLD_EN).
// Rev 1.0 - initial release
// ============================================================================
module mag_sqrd_integrator #(
  parameter int DW     = 16,
  parameter int LOG2_N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  mag_sqrd_integrator_if.slave    bus
);

  localparam int MW = 2 * DW;
  localparam int AW = MW + LOG2_N;
  localparam logic [LOG2_N-1:0] LAST_IDX = '1;
  localparam logic [LOG2_N-1:0] ONE_IDX  = LOG2_N'(1);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [LOG2_N-1:0] count_q, count_d;
  logic [MW-1:0]     power_q, power_d;
  logic              valid_q, valid_d;
  logic              detect_q, detect_d;
  logic [MW-1:0]     mean;

  // Truncating divide by N is just dropping the low LOG2_N bits.
  assign mean = acc_q[AW-1:LOG2_N];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    power_d  = power_q;
    valid_d  = 1'b0;
    detect_d = detect_q;

    if (bus.clear_i) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.valid_i) begin
            acc_d = acc_q + AW'(bus.mag_sqrd_i);
            if (count_q == LAST_IDX) begin
              count_d = '0;
              state_d = EMIT;
            end else begin
              count_d = count_q + ONE_IDX;
            end
          end
        end
        EMIT: begin
          power_d = mean;
          valid_d = 1'b1;
          if (mean >= bus.threshold_i) begin
            detect_d = 1'b1;
          end else if (mean < (bus.threshold_i >> 1)) begin
            detect_d = 1'b0;
          end
          // A sample arriving here opens the next window.
          if (bus.valid_i) begin
            acc_d   = AW'(bus.mag_sqrd_i);
            count_d = ONE_IDX;
          end else begin
            acc_d   = '0;
            count_d = '0;
          end
          state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ACCUM;
      acc_q    <= '0;
      count_q  <= '0;
      power_q  <= '0;
      valid_q  <= 1'b0;
      detect_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      power_q  <= power_d;
      valid_q  <= valid_d;
      detect_q <= detect_d;
    end
  end

  assign bus.power_o  = power_q;
  assign bus.valid_o  = valid_q;
  assign bus.detect_o = detect_q;

`ifdef PEAK_HOLD_EN
  logic [MW-1:0] run_peak_q, run_peak_d;
  logic [MW-1:0] peak_q, peak_d;

  // The Nth sample is already folded into run_peak_q when EMIT is reached.
  always_comb begin
    run_peak_d = run_peak_q;
    peak_d     = peak_q;
    if (bus.clear_i) begin
      run_peak_d = '0;
    end else if (state_q == EMIT) begin
      peak_d     = run_peak_q;
      run_peak_d = bus.valid_i ? bus.mag_sqrd_i : '0;
    end else if (bus.valid_i && (bus.mag_sqrd_i > run_peak_q)) begin
      run_peak_d = bus.mag_sqrd_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_peak_q <= '0;
      peak_q     <= '0;
    end else begin
      run_peak_q <= run_peak_d;
      peak_q     <= peak_d;
    end
  end

  assign bus.peak_o = peak_q;
`else
  assign bus.peak_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mag_sqrd_integrator.sv
`default_nettype none
// ============================================================================
// tb_mag_sqrd_integrator : directed checks, DW=16, LOG2_N=2 (N=4)
// Rev 1.0 - initial release
// ============================================================================
module tb_mag_sqrd_integrator;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mag_sqrd_integrator_if #(.DW(16)) bus ();

  mag_sqrd_integrator #(.DW(16), .LOG2_N(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_peak(input logic [31:0] v);
`ifdef PEAK_HOLD_EN
    return v;
`else
    return 32'd0;
`endif
  endfunction

  // Drives at the negedge; the DUT captures at the following posedge.
  task automatic drive_window(input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      bus.valid_i    = 1'b1;
      bus.mag_sqrd_i = v;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.power_o !== 32'd0 || bus.detect_o !== 1'b0 || bus.peak_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b p=%0d d=%b pk=%0d, want all 0",
               bus.valid_o, bus.power_o, bus.detect_o, bus.peak_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] samples [4];
    int early;
    samples = '{32'd100, 32'd200, 32'd300, 32'd400};
    bus.threshold_i = 32'd250;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      bus.valid_i    = 1'b1;
      bus.mag_sqrd_i = samples[i];
      @(negedge clk);
      bus.valid_i = 1'b0;
      if (bus.valid_o) early++;
      if (i < 3) begin
        repeat (2) begin
          @(negedge clk);
          if (bus.valid_o) early++;
        end
      end
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL basic_early_valid: got %0d pulses before latency 2, want 0", early);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.power_o !== 32'd250 || bus.detect_o !== 1'b1 || bus.peak_o !== exp_peak(32'd400)) begin
      errors++;
      $display("FAIL basic_result: got v=%b p=%0d d=%b pk=%0d, want v=1 p=250 d=1 pk=%0d",
               bus.valid_o, bus.power_o, bus.detect_o, bus.peak_o, exp_peak(32'd400));
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.power_o !== 32'd250 || bus.peak_o !== exp_peak(32'd400)) begin
      errors++;
      $display("FAIL basic_hold: got v=%b p=%0d pk=%0d, want v=0 p=250 pk=%0d",
               bus.valid_o, bus.power_o, bus.peak_o, exp_peak(32'd400));
    end
  endtask

  task automatic test_hysteresis;
    bus.threshold_i = 32'd250;
    for (int w = 0; w < 2; w++) begin
      drive_window(32'd130);
      @(negedge clk);
      checks++;
      if (bus.valid_o !== 1'b1 || bus.power_o !== 32'd130 || bus.detect_o !== 1'b1) begin
        errors++;
        $display("FAIL hyst_hold_w%0d: got v=%b p=%0d d=%b, want v=1 p=130 d=1",
                 w, bus.valid_o, bus.power_o, bus.detect_o);
      end
    end
    drive_window(32'd124);
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.power_o !== 32'd124 || bus.detect_o !== 1'b0) begin
      errors++;
      $display("FAIL hyst_clear: got v=%b p=%0d d=%b, want v=1 p=124 d=0",
               bus.valid_o, bus.power_o, bus.detect_o);
    end
  endtask

  task automatic test_no_wrap;
    bus.threshold_i = 32'd250;
    drive_window(32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.power_o !== 32'hFFFF_FFFF || bus.detect_o !== 1'b1 || bus.peak_o !== exp_peak(32'hFFFF_FFFF)) begin
      errors++;
      $display("FAIL no_wrap: got v=%b p=%h d=%b pk=%h, want v=1 p=ffffffff d=1 pk=%h",
               bus.valid_o, bus.power_o, bus.detect_o, bus.peak_o, exp_peak(32'hFFFF_FFFF));
    end
  endtask

  task automatic test_back_to_back;
    int bad_pulse;
    bad_pulse = 0;
    for (int i = 1; i <= 8; i++) begin
      bus.valid_i    = 1'b1;
      bus.mag_sqrd_i = 32'(i);
      @(negedge clk);
      if (bus.valid_o !== (i == 5)) bad_pulse++;
      if (i == 5) begin
        checks++;
        if (bus.power_o !== 32'd2 || bus.detect_o !== 1'b0 || bus.peak_o !== exp_peak(32'd4)) begin
          errors++;
          $display("FAIL b2b_window1: got p=%0d d=%b pk=%0d, want p=2 d=0 pk=%0d",
                   bus.power_o, bus.detect_o, bus.peak_o, exp_peak(32'd4));
        end
      end
    end
    bus.valid_i = 1'b0;
    checks++;
    if (bad_pulse !== 0) begin
      errors++;
      $display("FAIL b2b_pulse_timing: got %0d misplaced valid_o cycles, want 0", bad_pulse);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.power_o !== 32'd6 || bus.peak_o !== exp_peak(32'd8)) begin
      errors++;
      $display("FAIL b2b_window2: got v=%b p=%0d pk=%0d, want v=1 p=6 pk=%0d",
               bus.valid_o, bus.power_o, bus.peak_o, exp_peak(32'd8));
    end
  endtask

  task automatic test_clear;
    int pulses;
    pulses = 0;
    bus.threshold_i = 32'd250;
    for (int i = 0; i < 2; i++) begin
      bus.valid_i    = 1'b1;
      bus.mag_sqrd_i = 32'd1000;
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    bus.clear_i    = 1'b1;
    bus.mag_sqrd_i = 32'd9999;
    @(negedge clk);
    if (bus.valid_o) pulses++;
    bus.clear_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.valid_i    = 1'b1;
      bus.mag_sqrd_i = 32'd8;
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    bus.valid_i = 1'b0;
    checks++;
    if (pulses !== 0 || bus.power_o !== 32'd6) begin
      errors++;
      $display("FAIL clear_no_early: got pulses=%0d p=%0d, want pulses=0 p=6", pulses, bus.power_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.power_o !== 32'd8 || bus.peak_o !== exp_peak(32'd8)) begin
      errors++;
      $display("FAIL clear_result: got v=%b p=%0d pk=%0d, want v=1 p=8 pk=%0d",
               bus.valid_o, bus.power_o, bus.peak_o, exp_peak(32'd8));
    end
    // Clear landing in EMIT must suppress the pulse and leave outputs held.
    drive_window(32'd500);
    bus.clear_i = 1'b1;
    @(negedge clk);
    bus.clear_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.power_o !== 32'd8 || bus.detect_o !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_emit: got v=%b p=%0d d=%b, want v=0 p=8 d=0",
               bus.valid_o, bus.power_o, bus.detect_o);
    end
  endtask

  task automatic test_rst_mid;
    int pulses;
    pulses = 0;
    bus.threshold_i = 32'd30;
    for (int i = 0; i < 3; i++) begin
      bus.valid_i    = 1'b1;
      bus.mag_sqrd_i = 32'd50;
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.power_o !== 32'd0 || bus.detect_o !== 1'b0 || bus.peak_o !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got v=%b p=%0d d=%b pk=%0d, want all 0",
               bus.valid_o, bus.power_o, bus.detect_o, bus.peak_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.valid_i    = 1'b1;
      bus.mag_sqrd_i = 32'd40;
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    bus.valid_i = 1'b0;
    checks++;
    if (pulses !== 0 || bus.power_o !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_stale: got pulses=%0d p=%0d, want pulses=0 p=0", pulses, bus.power_o);
    end
    @(negedge clk);
    checks++;
    if (bus.valid_o !== 1'b1 || bus.power_o !== 32'd40 || bus.detect_o !== 1'b1 || bus.peak_o !== exp_peak(32'd40)) begin
      errors++;
      $display("FAIL rst_mid_result: got v=%b p=%0d d=%b pk=%0d, want v=1 p=40 d=1 pk=%0d",
               bus.valid_o, bus.power_o, bus.detect_o, bus.peak_o, exp_peak(32'd40));
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.valid_i     = 1'b0;
    bus.clear_i     = 1'b0;
    bus.mag_sqrd_i  = '0;
    bus.threshold_i = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_hysteresis();
    test_no_wrap();
    test_back_to_back();
    test_clear();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mag_sqrd_integrator.md
MAG_SQRD_INTEGRATOR -- requirements
Module: mag_sqrd_integrator

Interface
- REQ-001 Parameter DW, default 16: component width of the upstream complex sample; magnitude-squared input is 2*DW bits.
- REQ-002 Parameter LOG2_N, default 4: window length N = 2**LOG2_N samples; legal range 1..8.
- REQ-003 clk  input  1  single clock; all logic on rising edge.
- REQ-004 rst  input  1  reset, synchronous, active-high.
- REQ-005 mag_sqrd_i  input  2*DW  unsigned magnitude-squared sample from the upstream converter.
- REQ-006 valid_i  input  1  mag_sqrd_i qualifier; one sample per high cycle; back-to-back legal.
- REQ-007 clear_i  input  1  synchronous window abort/restart.
- REQ-008 threshold_i  input  2*DW  unsigned detect threshold, sampled in EMIT.
- REQ-009 power_o  output  2*DW  window mean power, registered.
- REQ-010 valid_o  output  1  one-cycle pulse qualifying power_o/peak_o.
- REQ-011 detect_o  output  1  hysteretic signal-present flag, registered.
- REQ-012 peak_o  output  2*DW  largest sample in the last window (see Configuration).

Function
- REQ-013 Internal accumulator SHALL be 2*DW+LOG2_N bits unsigned; no overflow or saturation is possible.
- REQ-014 Sample counter SHALL be LOG2_N bits, counting accepted samples in the current window.
- REQ-015 FSM SHALL have two states: ACCUM and EMIT; reset state ACCUM.
- REQ-016 ACCUM, valid_i=1, count<N-1: acc <= acc+mag_sqrd_i, count <= count+1.
- REQ-017 ACCUM, valid_i=1, count==N-1: acc <= acc+mag_sqrd_i, count <= 0, next state EMIT.
- REQ-018 ACCUM, valid_i=0: acc, count, state hold.
- REQ-019 EMIT: power_o <= acc[2*DW+LOG2_N-1:LOG2_N] (truncating divide by N), valid_o <= 1, detect_o updated per REQ-021; next state ACCUM unconditionally.
- REQ-020 EMIT, valid_i=1: sample SHALL NOT be lost; acc <= mag_sqrd_i, count <= 1 (first sample of next window); valid_i=0: acc <= 0, count <= 0.
- REQ-021 Detect hysteresis in EMIT: mean >= threshold_i sets detect_o; mean < (threshold_i>>1) clears it; otherwise holds. detect_o changes only in EMIT.
- REQ-022 valid_o SHALL be high exactly one cycle, in the cycle after EMIT; i.e. latency 2 cycles from the valid_i cycle of the Nth sample.
- REQ-023 power_o, peak_o SHALL hold their values between valid_o pulses.
- REQ-024 clear_i=1 (any state): acc <= 0, count <= 0, state <= ACCUM, no valid_o generated; a simultaneous valid_i sample SHALL be dropped; power_o, detect_o, peak_o hold.
- REQ-025 Throughput: valid_i high every cycle SHALL be accepted with no stall; one valid_o per N samples.

Reset
- REQ-026 rst SHALL take priority over clear_i and valid_i.
- REQ-027 On rst: state ACCUM, acc 0, count 0, running peak 0, power_o 0, valid_o 0, detect_o 0, peak_o 0.
- REQ-028 rst mid-window SHALL discard the partial window; first valid_o after release requires N fresh samples.

Configuration
- REQ-029 Macro PEAK_HOLD_EN defined: running max of accepted samples tracked per window (same load/clear rules as acc per REQ-016..020, REQ-024); in EMIT peak_o <= max(running peak, sample accepted in the Nth cycle).
- REQ-030 PEAK_HOLD_EN undefined: peak tracking logic absent; peak_o tied to 0; all other behaviour identical.

Verification (DW=16, LOG2_N=2, N=4)
- REQ-031 Samples 100,200,300,400 spaced 3 cycles, threshold 250 -> valid_o one pulse 2 cycles after 4th sample, power_o=250, detect_o=1, peak_o=400 (with PEAK_HOLD_EN, else 0).
- REQ-032 detect_o=1, threshold 250, then windows of mean 130 -> detect_o stays 1; then mean 124 -> detect_o=0 on that window's valid_o.
- REQ-033 Four samples 0xFFFFFFFF -> power_o=0xFFFFFFFF (no wrap).
- REQ-034 valid_i high 8 consecutive cycles with values 1..8 -> two valid_o pulses, power_o=2 then 6; sample 5 arriving in EMIT counted in window 2.
- REQ-035 Two samples of 1000, then clear_i with valid_i=1 (value 9999), then 4 samples of 8 -> single valid_o, power_o=8, peak_o=8.
- REQ-036 rst asserted after 3 samples, then 4 samples of 40 -> outputs 0 during/after reset, one valid_o with power_o=40.
